// File: rtl/adder_pkg.sv
// Shared definitions for the datapath adder and the ALU status register.
//   ADD_W            default operand width
//   FLG_C/V/Z/N      bit positions of the flags inside flags_t
//   flags_t          packed {n, z, v, c}; c lands in bit 0, n in bit 3
package adder_pkg;

    localparam int ADD_W = 8;

    localparam int FLG_C = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/adder_cla4.sv
// Combinational 4-bit carry-lookahead slice.
//   a, b  4-bit operands
//   ci    carry in
//   s     4-bit sum
//   co    carry out
//   g, p  group generate / propagate of the slice
module adder_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       g,
    output logic       p
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is a flat function of ci and the bit g/p terms, so no
    // carry waits on the one below it inside the slice.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);

    assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign p = &w_p;

    assign w_c[4] = g | (p & ci);

    assign s  = w_p ^ w_c[3:0];
    assign co = w_c[4];

endmodule

// File: rtl/adder_8b.sv
// Registered add/subtract unit for PC increment, address offsets and ALU ops.
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          operands valid this cycle
//   a, b, cin, sub    sub=0: a+b+cin ; sub=1: a+~b+cin (cin=1 means no borrow in)
//   y, out_valid      result one cycle after an accepted operand pair
//   cout, ovf,        carry out (sub: 1 = no borrow), signed overflow,
//   zero, neg         y==0, y MSB
module adder_8b
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NSL = WIDTH / 4;

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic [NSL:0]     w_c;
    logic [NSL-1:0]   w_grp_g;
    logic [NSL-1:0]   w_grp_p;
    logic             w_unused_grp;
    flags_t           w_flags;

    logic [WIDTH-1:0] r_y;
    flags_t           r_flags;
    logic             r_valid;

    assign w_b_eff = sub ? ~b : b;
    assign w_c[0]  = cin;

    // Slices ripple into each other through co.
    for (genvar i = 0; i < NSL; i++) begin : g_slice
        adder_cla4 u_cla4 (
            .a  (a[4*i +: 4]),
            .b  (w_b_eff[4*i +: 4]),
            .ci (w_c[i]),
            .s  (w_sum[4*i +: 4]),
            .co (w_c[i+1]),
            .g  (w_grp_g[i]),
            .p  (w_grp_p[i])
        );
    end

    // Group g/p are left for a second lookahead level if the width grows;
    // a short ripple between slices is fast enough here.
    assign w_unused_grp = ^{w_grp_g, w_grp_p};

    always_comb begin
        w_flags   = '0;
        w_flags.c = w_c[NSL];
        w_flags.v = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        w_flags.z = (w_sum == '0);
        w_flags.n = w_sum[WIDTH-1];
    end

    // Result and flags only load on accepted operands, so garbage on the
    // inputs while in_valid is low never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_flags <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_y     <= w_sum;
                r_flags <= w_flags;
            end
        end
    end

    assign y         = r_y;
    assign out_valid = r_valid;
    assign cout      = r_flags[FLG_C];
    assign ovf       = r_flags[FLG_V];
    assign zero      = r_flags[FLG_Z];
    assign neg       = r_flags[FLG_N];

endmodule

// File: tb/tb_adder_8b.sv
// Scoreboard bench for adder_8b: stimulus pushes expected results, a
// negedge monitor pops and compares whenever out_valid is seen.
module tb_adder_8b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] y;
    logic       out_valid, cout, ovf, zero, neg;

    adder_8b #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .y(y), .out_valid(out_valid), .cout(cout),
        .ovf(ovf), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic       c, v, z, n;
        int         due;
    } exp_t;

    typedef struct {
        logic [7:0] a, b;
        logic       cin, sub;
        logic [7:0] y;
        logic       c, v, z, n;
    } vec_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_y"},   y,         0);
        chk({nm, "_ov"},  out_valid, 0);
        chk({nm, "_c"},   cout,      0);
        chk({nm, "_v"},   ovf,       0);
        chk({nm, "_z"},   zero,      0);
        chk({nm, "_n"},   neg,       0);
    endtask

    // Independent reference for the random sweep.
    function automatic exp_t model(input logic [7:0] ia, ib, input logic ic, is);
        exp_t       e;
        logic [7:0] be;
        logic [8:0] full;
        be   = is ? ~ib : ib;
        full = {1'b0, ia} + {1'b0, be} + {8'b0, ic};
        e.y  = full[7:0];
        e.c  = full[8];
        e.v  = (ia[7] == be[7]) && (full[7] != ia[7]);
        e.z  = (full[7:0] == 8'h00);
        e.n  = full[7];
        e.due = 0;
        return e;
    endfunction

    task automatic issue(input logic [7:0] ia, ib, input logic ic, is, input exp_t e);
        exp_t ee;
        @(negedge clk);
        in_valid = 1'b1; a = ia; b = ib; cin = ic; sub = is;
        ee = e;
        ee.due = cyc + 1;
        q.push_back(ee);
    endtask

    task automatic issue_vec(input vec_t v);
        exp_t e;
        e.y = v.y; e.c = v.c; e.v = v.v; e.z = v.z; e.n = v.n; e.due = 0;
        issue(v.a, v.b, v.cin, v.sub, e);
    endtask

    // Monitor: compares the next expected entry whenever a result appears.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", cyc, e.due);
                    chk("y",    y,    e.y);
                    chk("cout", cout, e.c);
                    chk("ovf",  ovf,  e.v);
                    chk("zero", zero, e.z);
                    chk("neg",  neg,  e.n);
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                chk("missing_valid", out_valid, 1);
            end
        end
    end

    // Hand-computed directed vectors: a, b, cin, sub -> y, c, v, z, n
    vec_t dir[10] = '{
        '{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0},
        '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1},
        '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0},
        '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1},
        '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0},
        '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0},
        '{8'h55, 8'h55, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0},
        '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0},
        '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b0}
    };

    vec_t b2b[3] = '{
        '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0},
        '{8'h20, 8'h30, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0},
        '{8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1}
    };

    initial begin
        rst_n = 1'b0; in_valid = 1'b1;
        a = 8'hA5; b = 8'h5A; cin = 1'b1; sub = 1'b0;

        // Reset held with live inputs: nothing may load.
        #1 chk_cleared("rst_init");
        repeat (3) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            chk_cleared("rst_hold");
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b1;

        foreach (dir[i]) issue_vec(dir[i]);
        @(negedge clk) in_valid = 1'b0;
        @(negedge clk);

        // Three back-to-back results, then two idle cycles holding the last sum.
        foreach (b2b[i]) issue_vec(b2b[i]);
        @(negedge clk) in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("hold_ov", out_valid, 0);
            chk("hold_y",  y,         8'hFE);
            chk("hold_n",  neg,       1);
        end

        // Asynchronous reset while a result is on the outputs.
        issue_vec(dir[2]);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1 chk_cleared("rst_async");
        @(negedge clk) in_valid = 1'b0;
        #2 rst_n = 1'b1;

        // Random sweep, full throughput.
        for (int i = 0; i < 10000; i++) begin
            logic [7:0] ra, rb;
            logic       rc, rs;
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            issue(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        @(negedge clk) in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_8b.md
Name: adder_8b

Overview:
- Registered two-operand adder/subtractor for the microProcessor datapath, used for PC increment, address offsets and ALU add/sub.
- Takes two WIDTH-bit operands and an optional carry-in, and produces a WIDTH-bit sum with status flags.
- One-cycle latency, with a valid qualifier alongside the result.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of 4.

Ports:
- clk  input  1  system clock, rising edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode); borrow-in inverted (sub mode)
- sub  input  1  0 = add a+b+cin; 1 = subtract a+~b+cin
- y  output  WIDTH  registered result
- out_valid  output  1  y and flags are valid
- cout  output  1  carry out of MSB (sub mode: 1 = no borrow)
- ovf  output  1  signed overflow
- zero  output  1  y == 0
- neg  output  1  y[WIDTH-1]

Behaviour:
- One clock and one reset.
- Reset is asynchronous and active-low via rst_n.
- While rst_n = 0: y, cout, ovf, zero, neg and out_valid are all 0.
- Release of rst_n takes effect at the next rising clk edge; no result is produced on that edge.
- Operand selection: b_eff = sub ? ~b : b.
- Sum: {c, s} = a + b_eff + cin, computed at WIDTH+1 bits. The upper bit is discarded from y, so y wraps modulo 2^WIDTH.
- Flags:
  - ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]).
  - zero = (s == 0).
  - neg = s[MSB].
  - cout = c.
- Latency is exactly 1 cycle. On the rising edge where in_valid = 1, the result and flags register and out_valid = 1 in the following cycle.
- When in_valid = 0:
  - out_valid is 0 on the next cycle.
  - y and the flags hold their previous values; they do not update.
- Back-to-back in_valid gives a full-throughput pipeline, one result per cycle. There is no backpressure and no ready signal.
- Reset asserted mid-operation clears everything immediately (asynchronously); any in-flight result is lost.
- Inputs are sampled only at the clock edge. X on inputs while in_valid = 0 must not propagate to the outputs.
- Adder structure: a chain of 4-bit carry-lookahead slices with ripple between slices, all combinational ahead of the output register.
- Combinational depth target: one WIDTH-bit add plus the flag logic per cycle.

Decomposition:
- Shared package adder_pkg:
  - ADD_W = 8 default width constant.
  - Flag index constants FLG_C = 0, FLG_V = 1, FLG_Z = 2, FLG_N = 3, for the ALU status register.
  - Typedef flags_t: a 4-bit packed struct {n, z, v, c}.
- One sub-module: adder_cla4, a combinational 4-bit carry-lookahead slice.
  - Ports: a[3:0], b[3:0], ci, s[3:0], co, plus g/p group outputs.
  - Instantiated WIDTH/4 times.
- The top level holds the operand inversion, slice chaining, flag logic and output registers.

Test Plan:
- Reset: hold rst_n = 0 with random inputs and in_valid = 1 -> y = 0, all flags = 0, out_valid = 0; assert rst_n mid-stream -> outputs clear without waiting for a clock edge.
- Basic add: a = 8'h05, b = 8'h03, cin = 0, sub = 0, in_valid = 1 -> one cycle later y = 8'h08, cout = 0, ovf = 0, zero = 0, neg = 0, out_valid = 1.
- Unsigned wrap: a = 8'hFF, b = 8'h01, cin = 0 -> y = 8'h00, cout = 1, zero = 1, ovf = 0.
- Signed overflow: a = 8'h7F, b = 8'h01 -> y = 8'h80, ovf = 1, neg = 1, cout = 0.
- Subtract: sub = 1, cin = 1:
  - a = 8'h10, b = 8'h01 -> y = 8'h0F, cout = 1.
  - a = 8'h00, b = 8'h01 -> y = 8'hFF, cout = 0, neg = 1.
- Pipelining and hold: drive three back-to-back valid pairs, then in_valid = 0 for 2 cycles -> three consecutive correct results with out_valid = 1, then out_valid = 0 with y holding the last sum. Also run a random self-checking sweep of 10k vectors against a+b_eff+cin.
